// File: rtl/up_timer_mmss_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : timer_pkg
//  Description : Shared types and constants for the MM:SS up-timer digit chain
//  Revision    : 1.0 - initial release
// ============================================================================
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_FULL  = 2'd3
  } state_t;

  localparam logic [3:0] BCD_MAX_DIGIT = 4'd9;
  localparam logic [3:0] SEC_TENS_MAX  = 4'd5;

  // Tens digit of a two-digit minute limit
  function automatic logic [3:0] lim_tens(input int lim);
    return 4'(lim / 10);
  endfunction

  // Units digit of a two-digit minute limit
  function automatic logic [3:0] lim_units(input int lim);
    return 4'(lim % 10);
  endfunction

  // Roll-over value of each digit position: 0=sec units, 1=sec tens, 2/3=minutes
  function automatic logic [3:0] digit_max(input int idx);
    return (idx == 1) ? SEC_TENS_MAX : BCD_MAX_DIGIT;
  endfunction

endpackage
`default_nettype wire

// File: rtl/up_timer_mmss_if.sv
`default_nettype none
// ============================================================================
//  Module      : up_timer_mmss_if
//  Description : Control pulses and display/status outputs of the up-timer
//  Revision    : 1.0 - initial release
// ============================================================================
interface up_timer_mmss_if;
  logic       CE;
  logic       start;
  logic       clear;
  logic       lap;
  logic [3:0] sec_ones;
  logic [3:0] sec_tens;
  logic [3:0] min_ones;
  logic [3:0] min_tens;
  logic       running;
  logic       full;
  logic       lap_active;

  // Controller / stimulus side
  modport master (
    output CE, start, clear, lap,
    input  sec_ones, sec_tens, min_ones, min_tens, running, full, lap_active
  );

  // Timer side
  modport slave (
    input  CE, start, clear, lap,
    output sec_ones, sec_tens, min_ones, min_tens, running, full, lap_active
  );
endinterface
`default_nettype wire

// File: rtl/up_timer_mmss_bcd_up_digit.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_up_digit
//  Description : One BCD up-counting digit with carry-out, rolls MAX -> 0
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_up_digit
  import timer_pkg::*;
#(
  parameter logic [3:0] MAX = BCD_MAX_DIGIT
) (
  input  wire logic       clk,
  input  wire logic       reset,
  input  wire logic       clr,
  input  wire logic       CE,
  output logic            CEO,
  output logic [3:0]      count
);

  logic [3:0] count_q;
  logic [3:0] count_d;

  // Next digit value: clear wins, otherwise step with wrap at MAX
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = 4'd0;
    end else if (CE) begin
      count_d = (count_q == MAX) ? 4'd0 : count_q + 4'd1;
    end
  end

  // Digit register
  always_ff @(posedge clk) begin
    if (reset) count_q <= 4'd0;
    else       count_q <= count_d;
  end

  assign CEO   = (count_q == MAX) && CE;
  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/up_timer_mmss.sv
`default_nettype none
// ============================================================================
//  Module      : up_timer_mmss
//  Description : BCD MM:SS stopwatch, run/pause, clear, lap freeze, saturates
//                at MIN_LIMIT:59
//  Revision    : 1.0 - initial release
// ============================================================================
module up_timer_mmss
  import timer_pkg::*;
#(
  parameter int MIN_LIMIT = 99
) (
  input  wire logic       clk,
  input  wire logic       reset,
  up_timer_mmss_if.slave  bus
);

  localparam logic [3:0] MIN_TENS  = lim_tens(MIN_LIMIT);
  localparam logic [3:0] MIN_UNITS = lim_units(MIN_LIMIT);

  state_t      state_q, state_d;
  logic        running_q, running_d;
  logic        full_q, full_d;
  logic        lap_active_q, lap_active_d;
  logic [15:0] snap_q, snap_d;

  logic [3:0]  digit [4];
  logic [4:0]  carry;
  logic [15:0] live;
  logic [15:0] disp;
  logic        in_run;
  logic        saturating;

  assign in_run     = (state_q == ST_RUN);
  assign saturating = in_run && bus.CE &&
                      (digit[3] == MIN_TENS) && (digit[2] == MIN_UNITS) &&
                      (digit[1] == SEC_TENS_MAX) && (digit[0] == BCD_MAX_DIGIT);
  assign carry[0]   = in_run && bus.CE && !saturating;
  assign live       = {digit[3], digit[2], digit[1], digit[0]};

  // Four chained digits: sec units, sec tens, min units, min tens
  for (genvar i = 0; i < 4; i++) begin : g_digit
    bcd_up_digit #(
      .MAX (digit_max(i))
    ) u_digit (
      .clk   (clk),
      .reset (reset),
      .clr   (bus.clear),
      .CE    (carry[i]),
      .CEO   (carry[i+1]),
      .count (digit[i])
    );
  end

  // Next state, status flags and lap snapshot from pre-edge state and count
  always_comb begin
    state_d      = state_q;
    lap_active_d = lap_active_q;
    snap_d       = snap_q;
    if (bus.clear) begin
      state_d      = ST_IDLE;
      lap_active_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE:  if (bus.start) state_d = ST_RUN;
        // A carry out of the top digit would mean the limit was passed;
        // treat it like saturation so the count never silently wraps.
        ST_RUN:   if (bus.start)                    state_d = ST_PAUSE;
                  else if (saturating || carry[4])  state_d = ST_FULL;
        ST_PAUSE: if (bus.start) state_d = ST_RUN;
        ST_FULL:  state_d = ST_FULL;
        default:  state_d = ST_IDLE;
      endcase
      if (bus.lap && (state_q != ST_IDLE)) begin
        lap_active_d = !lap_active_q;
        if (!lap_active_q) snap_d = live;
      end
    end
    running_d = (state_d == ST_RUN);
    full_d    = (state_d == ST_FULL);
  end

  // Control FSM with registered status outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      running_q    <= 1'b0;
      full_q       <= 1'b0;
      lap_active_q <= 1'b0;
      snap_q       <= 16'h0000;
    end else begin
      state_q      <= state_d;
      running_q    <= running_d;
      full_q       <= full_d;
      lap_active_q <= lap_active_d;
      snap_q       <= snap_d;
    end
  end

  assign disp           = lap_active_q ? snap_q : live;
  assign bus.min_tens   = disp[15:12];
  assign bus.min_ones   = disp[11:8];
  assign bus.sec_tens   = disp[7:4];
  assign bus.sec_ones   = disp[3:0];
  assign bus.running    = running_q;
  assign bus.full       = full_q;
  assign bus.lap_active = lap_active_q;

endmodule
`default_nettype wire

// File: tb/tb_up_timer_mmss.sv
`default_nettype none
// ============================================================================
//  Module      : tb_up_timer_mmss
//  Description : Vector-table bench for the MM:SS up-timer (MIN_LIMIT = 99)
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_up_timer_mmss;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  up_timer_mmss_if bus ();

  up_timer_mmss #(
    .MIN_LIMIT (99)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic        cl;
    logic        lp;
    logic        ce;
    int          reps;
    logic [15:0] disp;
    logic        run;
    logic        full;
    logic        lap;
  } vec_t;

  vec_t vecs[$];

  // Drive one set of pulses for 'reps' consecutive edges
  task automatic drive(input logic st, input logic cl, input logic lp,
                       input logic ce, input int reps);
    for (int k = 0; k < reps; k++) begin
      @(negedge clk);
      bus.start = st;
      bus.clear = cl;
      bus.lap   = lp;
      bus.CE    = ce;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.clear = 1'b0;
      bus.lap   = 1'b0;
      bus.CE    = 1'b0;
    end
  endtask

  task automatic check(input string name, input logic [15:0] disp,
                       input logic run, input logic full, input logic lap);
    logic [15:0] got_disp;
    logic [2:0]  got_flags;
    got_disp  = {bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
    got_flags = {bus.running, bus.full, bus.lap_active};
    n_checks++;
    if (got_disp !== disp) begin
      n_errors++;
      $display("FAIL %s display got=%h required=%h", name, got_disp, disp);
    end
    n_checks++;
    if (got_flags !== {run, full, lap}) begin
      n_errors++;
      $display("FAIL %s run/full/lap got=%b required=%b", name, got_flags, {run, full, lap});
    end
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    bus.start = 1'b0;
    bus.clear = 1'b0;
    bus.lap   = 1'b0;
    bus.CE    = 1'b0;
    reset     = 1'b1;

    //            st    cl    lp    ce   reps  disp      run   full  lap
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0,    1, 16'h0000, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1,   75, 16'h0115, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0,    1, 16'h0000, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0,    1, 16'h0000, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1,    9, 16'h0009, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b1,    1, 16'h0010, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1,    3, 16'h0010, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0,    1, 16'h0010, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1,    1, 16'h0011, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1,  139, 16'h0230, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0,    1, 16'h0230, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1,   20, 16'h0230, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0,    1, 16'h0250, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1,  135, 16'h0505, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0,    1, 16'h0505, 1'b1, 1'b0, 1'b1});
    vecs.push_back('{1'b1, 1'b1, 1'b0, 1'b1,    1, 16'h0000, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0,    1, 16'h0000, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1,    3, 16'h0000, 1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0,    1, 16'h0000, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1,  599, 16'h0959, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1,    1, 16'h1000, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1, 5399, 16'h9959, 1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1,    1, 16'h9959, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0, 1'b0,    1, 16'h9959, 1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b1, 1'b0,    1, 16'h9959, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b0, 1'b1,    2, 16'h9959, 1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b1, 1'b0, 1'b0,    1, 16'h0000, 1'b0, 1'b0, 1'b0});

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset", 16'h0000, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].st, vecs[i].cl, vecs[i].lp, vecs[i].ce, vecs[i].reps);
      check($sformatf("row%0d", i), vecs[i].disp, vecs[i].run, vecs[i].full, vecs[i].lap);
    end

    // Reach FULL with the display frozen, then reset mid-operation
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 5999);
    check("to_9959", 16'h9959, 1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1);
    drive(1'b0, 1'b0, 1'b1, 1'b0, 1);
    check("full_lap", 16'h9959, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("reset_in_full", 16'h0000, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 4);
    check("idle_after_reset", 16'h0000, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
